// File: rtl/rr_seq_arbiter.sv
// rtl/rr_seq_arbiter.sv - round-robin arbiter and LDA/LDB/OUT sequencer; ARB_FIXED_PRIO_EN selects fixed priority
module rr_seq_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    sel1,
    output logic                    sel2,
    output logic                    mux1,
    output logic                    busy,
    output logic [NREQ-1:0]         done
);

    localparam int IDW = $clog2(NREQ);
    localparam int HW  = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_OUT  = 3'd3,
        S_REL  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_n;
    logic [IDW-1:0]  id_n;
    logic [IDW-1:0]  win_id;

    logic [NREQ-1:0] grant_n;
    logic [IDW-1:0]  gnt_id_n;
    logic            sel1_n;
    logic            sel2_n;
    logic            mux1_n;
    logic            busy_n;
    logic [NREQ-1:0] done_n;
    logic            active_n;

`ifdef ARB_FIXED_PRIO_EN
    // Lowest requesting index wins; scanning downwards leaves the lowest one in win_id.
    always_comb begin
        win_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_id = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_n;
    logic [IDW-1:0]  cand;
    logic            found;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // First requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_id = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_index(ptr, k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                win_id = cand;
            end
        end
    end
`endif

    // Next state, hold counter and grantee; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        id_n    = gnt_id;
`ifndef ARB_FIXED_PRIO_EN
        ptr_n   = ptr;
`endif
        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_n = S_LDA;
                    id_n    = win_id;
`ifndef ARB_FIXED_PRIO_EN
                    ptr_n   = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
`endif
                end
            end
            S_LDA: begin
                state_n = S_LDB;
            end
            S_LDB: begin
                state_n = S_OUT;
                hold_n  = HW'(HOLD - 1);
            end
            S_OUT: begin
                if (hold_cnt == '0) begin
                    state_n = S_REL;
                end else begin
                    hold_n = hold_cnt - HW'(1);
                end
            end
            S_REL: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                hold_n  = '0;
            end
        endcase

        active_n = (state_n != S_IDLE);
        grant_n  = active_n ? (NREQ'(1) << id_n) : '0;
        gnt_id_n = active_n ? id_n : '0;
        sel1_n   = (state_n == S_LDA);
        sel2_n   = (state_n == S_LDB);
        mux1_n   = (state_n == S_OUT);
        busy_n   = active_n;
        done_n   = (state_n == S_REL) ? grant_n : '0;
    end

    // State, counter, pointer and registered outputs; reset aborts any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            grant    <= '0;
            gnt_id   <= '0;
            sel1     <= 1'b0;
            sel2     <= 1'b0;
            mux1     <= 1'b0;
            busy     <= 1'b0;
            done     <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            grant    <= grant_n;
            gnt_id   <= gnt_id_n;
            sel1     <= sel1_n;
            sel2     <= sel2_n;
            mux1     <= mux1_n;
            busy     <= busy_n;
            done     <= done_n;
`ifndef ARB_FIXED_PRIO_EN
            ptr      <= ptr_n;
`endif
        end
    end

endmodule
